// File: rtl/cpu_pkg.sv
// Shared core definitions: machine width, the canonical NOP encoding and
// the fetch-unit state encoding.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HAND  = 3'd3,
        FAULT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: owns the architectural PC, fetches one instruction at a time
// and hands it to decode. The next PC arrives from branch resolution at retire.
//
// Handshakes: imem_req transfers on an edge where imem_req_valid && imem_req_ready.
// instr transfers (retires) on an edge where instr_valid && instr_ready. While
// valid is high, the payload stays stable until the transfer.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    input  logic [XLEN-1:0] next_pc,
    output logic            fetch_fault,
    output logic [XLEN-1:0] retire_count
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         retire;
    logic         next_pc_aligned;

    assign next_pc_aligned = (next_pc[1:0] == 2'b00);
    assign pc4             = pc + 32'd4;
    assign imem_req_addr   = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        retire         = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = HAND;
                end
            end
            HAND: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    retire  = 1'b1;
                    state_d = next_pc_aligned ? REQ : FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A misaligned target still retires the current instruction, but the PC
    // is left pointing at it so the faulting retire can be diagnosed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            instr        <= NOP_INSTR;
            fetch_fault  <= 1'b0;
            retire_count <= '0;
        end else begin
            if (state_q == WAIT && imem_rsp_valid) begin
                instr <= imem_rsp_data;
            end
            if (retire) begin
                retire_count <= retire_count + 32'd1;
                if (next_pc_aligned) begin
                    pc <= next_pc;
                end else begin
                    fetch_fault <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level PC/retire model
// drives a randomized imem and core, and compares every handoff.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        fetch_fault;
    logic [31:0] retire_count;

    int          total;
    int          bad;
    int          cyc;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_fault;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .pc4            (pc4),
        .next_pc        (next_pc),
        .fetch_fault    (fetch_fault),
        .retire_count   (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b0;
        next_pc        = '0;
        tick();
        tick();
        rst_n     = 1'b1;
        exp_pc    = RESET_PC;
        exp_cnt   = '0;
        exp_fault = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if ({imem_req_valid, instr_valid, fetch_fault} !== 3'b000) begin
            bad++;
            $display("FAIL %s_flags: got req=%b iv=%b fault=%b want 000", tag,
                     imem_req_valid, instr_valid, fetch_fault);
        end
        total++;
        if (pc !== RESET_PC || imem_req_addr !== RESET_PC || instr !== NOP || retire_count !== 32'd0) begin
            bad++;
            $display("FAIL %s_regs: got pc=%h addr=%h instr=%h cnt=%h want pc=%h instr=%h cnt=0",
                     tag, pc, imem_req_addr, instr, retire_count, RESET_PC, NOP);
        end
    endtask

    // One full fetch/retire. abort=1 returns once the request is accepted,
    // abort=2 returns once the instruction is presented to decode.
    task automatic do_instr(input logic [31:0] npc, input int stall, input int dly,
                            input int hold, input int abort);
        int w;
        w = 0;
        while (imem_req_valid !== 1'b1 && w < 8) begin
            tick();
            w++;
        end
        total++;
        if (imem_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL req_timeout: req_valid=%b after %0d cycles, want 1", imem_req_valid, w);
            return;
        end
        total++;
        if (imem_req_addr !== exp_pc) begin
            bad++;
            $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_pc);
        end
        for (int s = 0; s < stall; s++) begin
            imem_req_ready = 1'b0;
            instr_ready    = 1'($urandom_range(0, 1));
            next_pc        = $urandom;
            tick();
            total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
                bad++;
                $display("FAIL req_stall: got valid=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, exp_pc);
            end
        end
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        total++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL req_accept: got req=%b iv=%b want 0/0", imem_req_valid, instr_valid);
        end
        if (abort == 1) return;
        for (int d = 1; d < dly; d++) begin
            imem_rsp_valid = 1'b0;
            instr_ready    = 1'($urandom_range(0, 1));
            next_pc        = $urandom;
            tick();
            total++;
            if (instr_valid !== 1'b0 || retire_count !== exp_cnt) begin
                bad++;
                $display("FAIL rsp_wait: got iv=%b cnt=%h want 0/%h", instr_valid, retire_count, exp_cnt);
            end
        end
        instr_ready    = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(exp_pc);
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        total++;
        if (instr_valid !== 1'b1 || instr !== mem_word(exp_pc) || pc !== exp_pc || pc4 !== exp_pc + 32'd4) begin
            bad++;
            $display("FAIL handoff: got iv=%b instr=%h pc=%h pc4=%h want 1/%h/%h/%h",
                     instr_valid, instr, pc, pc4, mem_word(exp_pc), exp_pc, exp_pc + 32'd4);
        end
        if (abort == 2) return;
        for (int h = 0; h < hold; h++) begin
            instr_ready    = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_req_ready = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (instr_valid !== 1'b1 || instr !== mem_word(exp_pc) || pc !== exp_pc || imem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL hand_hold: got iv=%b instr=%h pc=%h req=%b want 1/%h/%h/0",
                         instr_valid, instr, pc, imem_req_valid, mem_word(exp_pc), exp_pc);
            end
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        next_pc        = npc;
        tick();
        instr_ready = 1'b0;
        next_pc     = $urandom;
        exp_cnt     = exp_cnt + 32'd1;
        if (npc[1:0] == 2'b00) exp_pc = npc;
        else exp_fault = 1'b1;
        total++;
        if (retire_count !== exp_cnt || fetch_fault !== exp_fault || pc !== exp_pc) begin
            bad++;
            $display("FAIL retire: got cnt=%h fault=%b pc=%h want %h/%b/%h",
                     retire_count, fetch_fault, pc, exp_cnt, exp_fault, exp_pc);
        end
    endtask

    task automatic test_reset();
        int t0;
        apply_reset();
        check_reset_values("reset");
        t0 = cyc;
        tick();
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            bad++;
            $display("FAIL first_req: got valid=%b addr=%h want 1/00000000", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(32'h0);
        tick();
        imem_rsp_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || cyc - t0 != 3 || pc !== 32'h0 || pc4 !== 32'h4 || instr !== mem_word(32'h0)) begin
            bad++;
            $display("FAIL first_instr: got iv=%b edges=%0d pc=%h pc4=%h instr=%h want 1/3/0/4/%h",
                     instr_valid, cyc - t0, pc, pc4, instr, mem_word(32'h0));
        end
    endtask

    task automatic test_sequential();
        int t0;
        apply_reset();
        tick();
        t0 = cyc;
        for (int i = 0; i < 5; i++) do_instr(exp_pc + 32'd4, 0, 1, 0, 0);
        total++;
        if (retire_count !== 32'd5 || cyc - t0 != 15 || pc !== 32'h14) begin
            bad++;
            $display("FAIL sequential: got cnt=%0d cycles=%0d pc=%h want 5/15/00000014", retire_count, cyc - t0, pc);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        do_instr(32'h4, 0, 1, 0, 0);
        do_instr(32'h8, 0, 1, 0, 0);
        do_instr(32'h40, 0, 1, 0, 0);
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
            bad++;
            $display("FAIL branch_target: got valid=%b addr=%h want 1/00000040", imem_req_valid, imem_req_addr);
        end
        do_instr(32'h44, 3, 2, 2, 0);
    endtask

    task automatic test_misaligned();
        logic [31:0] hold_pc;
        apply_reset();
        do_instr(32'h4, 0, 1, 0, 0);
        do_instr(32'h42, 0, 1, 0, 0);
        hold_pc = exp_pc;
        total++;
        if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== 32'h4) begin
            bad++;
            $display("FAIL misaligned: got fault=%b iv=%b req=%b pc=%h want 1/0/0/00000004",
                     fetch_fault, instr_valid, imem_req_valid, pc);
        end
        for (int i = 0; i < 8; i++) begin
            instr_ready    = 1'($urandom_range(0, 1));
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_req_ready = 1'($urandom_range(0, 1));
            next_pc        = {$urandom_range(0, 255), 2'b00};
            tick();
            total++;
            if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || imem_req_valid !== 1'b0 ||
                pc !== hold_pc || retire_count !== exp_cnt) begin
                bad++;
                $display("FAIL fault_sticky: got fault=%b iv=%b req=%b pc=%h cnt=%h want 1/0/0/%h/%h",
                         fetch_fault, instr_valid, imem_req_valid, pc, retire_count, hold_pc, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_instr(32'h10, 0, 1, 0, 0);
        do_instr(32'h0, 1, 1, 0, 1);
        rst_n = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
        tick();
        imem_rsp_valid = 1'b0;
        check_reset_values("reset_wait");
        apply_reset();
        do_instr(32'h20, 0, 1, 0, 0);
        do_instr(32'h0, 0, 2, 0, 2);
        rst_n = 1'b0;
        instr_ready = 1'b1;
        next_pc = 32'h3;
        tick();
        check_reset_values("reset_hand");
        apply_reset();
        do_instr(32'h4, 0, 1, 0, 0);
    endtask

    task automatic test_wrap();
        apply_reset();
        do_instr(32'hFFFF_FFFC, 0, 1, 0, 0);
        force dut.retire_count = 32'hFFFF_FFFE;
        #1;
        release dut.retire_count;
        exp_cnt = 32'hFFFF_FFFE;
        do_instr(32'h0, 1, 1, 1, 0);
        do_instr(32'h4, 0, 1, 0, 0);
        total++;
        if (retire_count !== 32'h0 || pc !== 32'h4) begin
            bad++;
            $display("FAIL wrap: got cnt=%h pc=%h want 00000000/00000004", retire_count, pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] npc;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: npc = exp_pc + 32'd4;
                1: npc = exp_pc;
                2: npc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                default: npc = exp_pc - 32'd8;
            endcase
            do_instr(npc, $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3), 0);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        cyc            = 0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        next_pc        = '0;
        exp_pc         = RESET_PC;
        exp_cnt        = '0;
        exp_fault      = 1'b0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_misaligned();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
